mem_access_unit: RTL

- Memory-stage bus master placed directly after the pipeline control registers' M-stage outputs (m_mem_size, m_mem_write, m_fb_write, m_result_src).
- Turns each M-stage load or store into a req/ack transaction on the data-memory bus.
- Buffers framebuffer pixel writes in a small FIFO so that they drain without stalling the pipeline.
- Asserts a stall to the hazard unit while a data access is outstanding, or while a framebuffer write cannot be accepted.

---
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// M-stage data-memory bus master with a posted framebuffer write FIFO.
// Loads/stores run one at a time on a req/ack bus; framebuffer stores drain in order.
module mem_access_unit #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned FB_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic              m_fb_write,
    input  logic [1:0]        m_mem_size,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_write_data,
    output logic              m_stall,
    output logic [DATA_W-1:0] m_read_data,
    output logic              m_misaligned,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              fb_valid,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic [3:0]        fb_be,
    input  logic              fb_ready
);

    localparam int unsigned PtrW = $clog2(FB_FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic              req_we_q, req_load_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [3:0]        req_be_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] fifo_addr [FB_FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FB_FIFO_DEPTH];
    logic [3:0]        fifo_be   [FB_FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;

    logic              misaligned;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [ADDR_W-1:0] word_addr;
    logic              in_idle, issue, is_load;
    logic              fifo_full, deq, enq_want, enq;

    always_comb begin
        misaligned = 1'b0;
        lane_be    = 4'h0;
        lane_wdata = m_write_data;
        case (m_mem_size)
            2'd0: begin
                lane_be    = 4'b0001 << m_addr[1:0];
                lane_wdata = {4{m_write_data[7:0]}};
            end
            2'd1: begin
                lane_be    = 4'b0011 << m_addr[1:0];
                lane_wdata = {2{m_write_data[15:0]}};
                misaligned = m_addr[0];
            end
            2'd2: begin
                lane_be    = 4'hF;
                misaligned = (m_addr[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign word_addr = {m_addr[ADDR_W-1:2], 2'b00};
    assign is_load   = m_mem_read & ~m_mem_write;
    // Outputs that decode the M inputs combinationally are gated so reset forces them low.
    assign in_idle   = reset & (state_q == StIdle);
    assign issue     = in_idle & m_valid & (m_mem_read | m_mem_write) & ~misaligned;

    assign m_misaligned = in_idle & m_valid & (m_mem_read | m_mem_write | m_fb_write) & misaligned;

    // Data-memory priority: a combined mem/fb store never reaches the FIFO.
    assign fifo_full = (count_q == CntW'(FB_FIFO_DEPTH));
    assign fb_valid  = (count_q != '0);
    assign deq       = fb_valid & fb_ready;
    assign enq_want  = in_idle & m_valid & m_fb_write & ~m_mem_write & ~misaligned;
    assign enq       = enq_want & (~fifo_full | deq);

    assign m_stall     = issue | (state_q == StWait) | (enq_want & ~enq);
    assign m_read_data = rdata_q;

    assign fb_addr = fb_valid ? fifo_addr[rd_ptr_q] : '0;
    assign fb_data = fb_valid ? fifo_data[rd_ptr_q] : '0;
    assign fb_be   = fb_valid ? fifo_be[rd_ptr_q]   : 4'h0;

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = 4'h0;
        if (state_q == StWait) begin
            dmem_req   = 1'b1;
            dmem_we    = req_we_q;
            dmem_addr  = req_addr_q;
            dmem_wdata = req_wdata_q;
            dmem_be    = req_be_q;
        end else if (issue) begin
            dmem_req   = 1'b1;
            dmem_we    = m_mem_write;
            dmem_addr  = word_addr;
            dmem_wdata = lane_wdata;
            dmem_be    = lane_be;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            req_we_q    <= 1'b0;
            req_load_q  <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= 4'h0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        req_we_q    <= m_mem_write;
                        req_load_q  <= is_load;
                        req_addr_q  <= word_addr;
                        req_wdata_q <= lane_wdata;
                        req_be_q    <= lane_be;
                        if (dmem_ack) begin
                            state_q <= StResp;
                            if (is_load) rdata_q <= dmem_rdata;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (dmem_ack) begin
                        state_q <= StResp;
                        if (req_load_q) rdata_q <= dmem_rdata;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr_q] <= word_addr;
            fifo_data[wr_ptr_q] <= lane_wdata;
            fifo_be[wr_ptr_q]   <= lane_be;
        end
    end

endmodule
